program_counter: RTL and testbench

The program counter register at the head of the instruction-fetch unit. It holds the address of the instruction currently being fetched. On every rising clock edge it loads the next address presented by the fetch datapath: PC+4, branch target or jump target, selected upstream. It drives that value to instruction memory and the PC incrementer. It applies no arithmetic of its own; next-address selection lives outside this block.

---
 rtl/program_counter.sv | 26 ++
 tb/tb_program_counter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Fetch-unit PC register: loads the upstream-selected next address every rising edge, synchronous reset.
// Latency 1 cycle; no backpressure, no enable or stall.
module program_counter #(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Address,
    output logic [WIDTH-1:0] PCResult
);

    logic [WIDTH-1:0] pc;

    // Reset wins over the load; the address is taken verbatim, with no alignment masking.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc <= RESET_VALUE;
        end else begin
            pc <= Address;
        end
    end

    assign PCResult = pc;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboarded bench for program_counter: two instances with default and non-zero reset values.
module tb_program_counter;

    typedef struct packed {
        logic [31:0] pc_a;
        logic [31:0] pc_b;
    } exp_t;

    localparam logic [31:0] RV_B = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] pc_a;
    logic [31:0] pc_b;

    exp_t        sb_q[$];
    int          total;
    int          bad;
    int          pushed;
    int          popped;
    logic [31:0] last_a;
    logic [31:0] last_b;

    program_counter #(.WIDTH(32), .RESET_VALUE(32'h0000_0000)) dut_a (
        .Clk(clk), .Reset(rst), .Address(addr), .PCResult(pc_a)
    );

    program_counter #(.WIDTH(32), .RESET_VALUE(RV_B)) dut_b (
        .Clk(clk), .Reset(rst), .Address(addr), .PCResult(pc_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one edge's worth of stimulus shortly after a rising edge and queues its result.
    task automatic step(input logic r, input logic [31:0] a);
        exp_t e;
        @(posedge clk);
        #2;
        rst  = r;
        addr = a;
        e.pc_a = r ? 32'h0000_0000 : a;
        e.pc_b = r ? RV_B : a;
        sb_q.push_back(e);
        pushed++;
        last_a = e.pc_a;
        last_b = e.pc_b;
    endtask

    // Changes Address mid-cycle: output must hold its old value until the next edge.
    task automatic step_mid(input logic [31:0] a_first, input logic [31:0] a_final);
        logic [31:0] prev_a;
        logic [31:0] prev_b;
        exp_t        e;
        prev_a = last_a;
        prev_b = last_b;
        @(posedge clk);
        #2;
        rst  = 1'b0;
        addr = a_first;
        #4;
        check("hold_early_a", pc_a, prev_a);
        addr = a_final;
        #2;
        check("hold_mid_a", pc_a, prev_a);
        check("hold_mid_b", pc_b, prev_b);
        e.pc_a = a_final;
        e.pc_b = a_final;
        sb_q.push_back(e);
        pushed++;
        last_a = e.pc_a;
        last_b = e.pc_b;
    endtask

    // Monitor: after every edge, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                popped++;
                check("pc_a", pc_a, e.pc_a);
                check("pc_b", pc_b, e.pc_b);
            end
        end
    end

    initial begin
        int guard;
        total  = 0;
        bad    = 0;
        pushed = 0;
        popped = 0;
        last_a = 'x;
        last_b = 'x;
        rst    = 1'b1;
        addr   = 32'hDEAD_BEEF;

        // Reset hold with Address ignored
        step(1'b1, 32'hDEAD_BEEF);
        step(1'b1, 32'hDEAD_BEEF);
        step(1'b1, 32'hDEAD_BEEF);

        // Sequential unaligned loads
        step(1'b0, 32'd1);
        step(1'b0, 32'd2);
        step(1'b0, 32'd3);
        step(1'b0, 32'd4);

        step_mid(32'h0000_0100, 32'h0000_0104);

        // Reset mid-run
        step(1'b0, 32'h0000_0040);
        step(1'b1, 32'h0000_0044);
        step(1'b0, 32'h0000_0008);

        // Full-width and boundary values
        step(1'b0, 32'hFFFF_FFFF);
        step(1'b0, 32'h0000_0000);
        step(1'b0, 32'h8000_0003);
        step(1'b0, 32'h7FFF_FFFE);
        step(1'b1, 32'h1234_5678);
        step(1'b0, 32'h0000_000C);
        step(1'b0, 32'hA5A5_5A5A);

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #5;
        total++;
        if (sb_q.size() != 0 || popped != pushed) begin
            bad++;
            $display("FAIL drain: popped %0d expected %0d pending %0d", popped, pushed, sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
